// File: rtl/speed_scheduler.sv
// Frame-driven difficulty scheduler: steps a speed level every FRAMES_PER_LEVEL frames of an active run
// and drives registered physics constants. Optional power-up boost is compiled in with SPEED_BOOST_EN.
module speed_scheduler #(
    parameter int FRAMES_PER_LEVEL = 1800,
    parameter int MAX_LEVEL        = 3,
    parameter int FCOUNT_W         = 12
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_in,
    input  logic       start_in,
    input  logic       pause_in,
    input  logic       game_over_in,
`ifdef SPEED_BOOST_EN
    input  logic       boost_in,
`endif
    output logic [1:0] level_out,
    output logic [3:0] speed_out,
    output logic [5:0] gravity_out,
    output logic [7:0] duck_limit_out,
    output logic [9:0] vertical_jump_out,
    output logic       level_up_out,
    output logic       running_out
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

    localparam logic [1:0]          MAX_LV     = 2'(MAX_LEVEL);
    localparam logic [FCOUNT_W-1:0] LAST_FRAME = FCOUNT_W'(FRAMES_PER_LEVEL - 1);

    state_t              state_reg, state_next;
    logic [1:0]          level_reg, level_next;
    logic [FCOUNT_W-1:0] count_reg, count_next;
    logic                level_up_reg, level_up_next;
    logic [3:0]          speed_reg;
    logic [5:0]          gravity_reg;
    logic [7:0]          duck_reg;
    logic [9:0]          jump_reg;
    logic [1:0]          eff_next;
    logic                frame_step;

    // Packed row: {speed, gravity, duck_limit, vertical_jump}
    function automatic logic [27:0] row(input logic [1:0] lv);
        case (lv)
            2'd0:    row = {4'd1, 6'd1,  8'd128, 10'd180};
            2'd1:    row = {4'd2, 6'd4,  8'd64,  10'd300};
            2'd2:    row = {4'd4, 6'd15, 8'd32,  10'd470};
            default: row = {4'd8, 6'd60, 8'd16,  10'd700};
        endcase
    endfunction

    // Game over outranks pause, and pause outranks a frame tick on the same cycle.
    assign frame_step = (state_reg == RUN) && !game_over_in && !pause_in && frame_in;

    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        count_next    = count_reg;
        level_up_next = 1'b0;
        unique case (state_reg)
            IDLE, OVER: begin
                if (start_in) begin
                    state_next = RUN;
                    level_next = 2'd0;
                    count_next = '0;
                end
            end
            RUN: begin
                if (game_over_in) begin
                    state_next = OVER;
                end else if (pause_in) begin
                    state_next = PAUSED;
                end else if (frame_step) begin
                    if (count_reg == LAST_FRAME) begin
                        count_next = '0;
                        if (level_reg < MAX_LV) begin
                            level_next    = level_reg + 2'd1;
                            level_up_next = 1'b1;
                        end
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (game_over_in)
                    state_next = OVER;
                else if (!pause_in)
                    state_next = RUN;
            end
        endcase
    end

`ifdef SPEED_BOOST_EN
    localparam logic [FCOUNT_W-1:0] BOOST_FRAMES = FCOUNT_W'(FRAMES_PER_LEVEL / 4);

    logic                boost_armed_reg, boost_armed_next;
    logic [FCOUNT_W-1:0] boost_left_reg, boost_left_next;

    // A request arms the boost; the next counted frame loads the duration.
    always_comb begin
        boost_armed_next = boost_armed_reg;
        boost_left_next  = boost_left_reg;
        if (frame_step) begin
            if (boost_armed_reg) begin
                boost_left_next  = BOOST_FRAMES;
                boost_armed_next = 1'b0;
            end else if (boost_left_reg != '0) begin
                boost_left_next = boost_left_reg - 1'b1;
            end
        end
        if (state_reg == RUN && !game_over_in && boost_in)
            boost_armed_next = 1'b1;
        if (state_next == OVER) begin
            boost_armed_next = 1'b0;
            boost_left_next  = '0;
        end
        eff_next = (boost_left_next != '0 && level_next != 2'd3) ? level_next + 2'd1 : level_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            boost_armed_reg <= 1'b0;
            boost_left_reg  <= '0;
        end else begin
            boost_armed_reg <= boost_armed_next;
            boost_left_reg  <= boost_left_next;
        end
    end
`else
    assign eff_next = level_next;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            level_reg    <= 2'd0;
            count_reg    <= '0;
            level_up_reg <= 1'b0;
            speed_reg    <= 4'd1;
            gravity_reg  <= 6'd1;
            duck_reg     <= 8'd128;
            jump_reg     <= 10'd180;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            count_reg    <= count_next;
            level_up_reg <= level_up_next;
            {speed_reg, gravity_reg, duck_reg, jump_reg} <= row(eff_next);
        end
    end

    assign level_out         = level_reg;
    assign speed_out         = speed_reg;
    assign gravity_out       = gravity_reg;
    assign duck_limit_out    = duck_reg;
    assign vertical_jump_out = jump_reg;
    assign level_up_out      = level_up_reg;
    assign running_out       = (state_reg == RUN);

endmodule

// File: tb/tb_speed_scheduler.sv
// Directed bench for speed_scheduler with a frame-arithmetic reference model checked every cycle.
module tb_speed_scheduler;
    localparam int FPL = 4, MAXL = 3, FW = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

    logic clk = 0, rst = 1, frame = 0, start = 0, pause = 0, go = 0, boost = 0;
    logic [1:0] level;
    logic [3:0] speed;
    logic [5:0] grav;
    logic [7:0] duck;
    logic [9:0] jump;
    logic       lvup, running;

    always #5 clk = ~clk;

    speed_scheduler #(.FRAMES_PER_LEVEL(FPL), .MAX_LEVEL(MAXL), .FCOUNT_W(FW)) dut (
        .clk_in(clk), .rst_in(rst), .frame_in(frame), .start_in(start),
        .pause_in(pause), .game_over_in(go),
`ifdef SPEED_BOOST_EN
        .boost_in(boost),
`endif
        .level_out(level), .speed_out(speed), .gravity_out(grav),
        .duck_limit_out(duck), .vertical_jump_out(jump),
        .level_up_out(lvup), .running_out(running)
    );

    int total = 0, bad = 0, pulses = 0;
    int m_mode = M_IDLE, m_frames = 0, m_level = 0, m_lvup = 0, m_armed = 0, m_left = 0;
    int e_speed[4] = '{1, 2, 4, 8};
    int e_grav[4]  = '{1, 4, 15, 60};
    int e_duck[4]  = '{128, 64, 32, 16};
    int e_jump[4]  = '{180, 300, 470, 700};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Level follows directly from frames counted in the run.
    function automatic int lvl_of(input int frames);
        return (frames / FPL > MAXL) ? MAXL : frames / FPL;
    endfunction

    function automatic int eff_level();
        if (m_left > 0) return (m_level + 1 > 3) ? 3 : m_level + 1;
        return m_level;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_frames = 0; m_level = 0; m_lvup = 0; m_armed = 0; m_left = 0;
        end else begin
            m_lvup = 0;
            case (m_mode)
                M_IDLE, M_OVER: if (start) begin m_mode = M_RUN; m_frames = 0; m_level = 0; end
                M_RUN: begin
                    if (go) begin
                        m_mode = M_OVER; m_armed = 0; m_left = 0;
                    end else begin
                        if (!pause && frame) begin
                            m_frames++;
                            if (m_armed != 0) begin m_left = FPL / 4; m_armed = 0; end
                            else if (m_left > 0) m_left--;
                            if (lvl_of(m_frames) > m_level) begin m_level = lvl_of(m_frames); m_lvup = 1; end
                        end
                        if (boost) m_armed = 1;
                        if (pause) m_mode = M_PAUSE;
                    end
                end
                default: begin
                    if (go) begin m_mode = M_OVER; m_armed = 0; m_left = 0; end
                    else if (!pause) m_mode = M_RUN;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int e;
        e = eff_level();
        chk("cyc_level", level, m_level);
        chk("cyc_speed", speed, e_speed[e]);
        chk("cyc_gravity", grav, e_grav[e]);
        chk("cyc_duck", duck, e_duck[e]);
        chk("cyc_jump", jump, e_jump[e]);
        chk("cyc_level_up", lvup, m_lvup);
        chk("cyc_running", running, m_mode == M_RUN);
        if (lvup === 1'b1) pulses++;
    end

    task automatic step(input logic f, input logic s, input logic g, input logic b);
        frame = f; start = s; go = g; boost = b;
        @(posedge clk); #1;
        frame = 0; start = 0; go = 0; boost = 0;
        $display("txn frame=%0b start=%0b pause=%0b over=%0b boost=%0b -> level=%0d speed=%0d grav=%0d up=%0b run=%0b",
                 f, s, pause, g, b, level, speed, grav, lvup, running);
    endtask

    task automatic chk_row(input string nm, input int lv, input int sp, input int gr, input int dk, input int jp);
        chk({nm, "_level"}, level, lv);
        chk({nm, "_speed"}, speed, sp);
        chk({nm, "_gravity"}, grav, gr);
        chk({nm, "_duck"}, duck, dk);
        chk({nm, "_jump"}, jump, jp);
    endtask

    initial begin
        int p0, p1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_row("reset", 0, 1, 1, 128, 180);
        chk("reset_level_up", lvup, 0);
        chk("reset_running", running, 0);
        rst = 0;

        step(0, 1, 0, 0);
        chk("start_running", running, 1);
        p0 = pulses;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk_row("frame4", 1, 2, 4, 64, 300);
        chk("frame4_level_up", lvup, 1);
        step(0, 0, 0, 0);
        chk("frame4_one_pulse", pulses - p0, 1);

        for (int i = 4; i < 12; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        p1 = pulses;
        for (int i = 12; i < 16; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_row("sat", 3, 8, 60, 16, 700);
        chk("sat_no_pulse_13_16", pulses - p1, 0);
        chk("sat_three_pulses", pulses - p0, 3);

        step(0, 1, 0, 0);
        chk("start_in_run_ignored", level, 3);
        step(0, 0, 1, 0);
        chk("over_running", running, 0);
        chk("over_hold_speed", speed, 8);
        step(0, 1, 1, 0);
        chk("restart_running", running, 1);
        chk("restart_speed", speed, 1);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        pause = 1;
        step(0, 0, 0, 0);
        chk("paused_running", running, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        chk("paused_level", level, 0);
        pause = 0;
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("unpaused3_level", level, 0);
        step(1, 0, 0, 0);
        chk("unpaused4_level", level, 1);
        chk("unpaused4_level_up", lvup, 1);

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("go_frame_level", level, 1);
        chk("go_frame_level_up", lvup, 0);
        chk("go_frame_running", running, 0);
        step(0, 1, 0, 0);
        chk("after_go_start_level", level, 0);
        chk("after_go_start_speed", speed, 1);

`ifdef SPEED_BOOST_EN
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("boost_armed_gravity", grav, 4);
        step(1, 0, 0, 0);
        chk_row("boost_on", 1, 4, 15, 32, 470);
        step(1, 0, 0, 0);
        chk_row("boost_off", 1, 2, 4, 64, 300);
`endif

        for (int i = 0; i < 12 && m_level < 2; i++) step(1, 0, 0, 0);
        chk_row("pre_reset", 2, 4, 15, 32, 470);
        #2 rst = 1;
        #1;
        chk_row("async_reset", 0, 1, 1, 128, 180);
        chk("async_reset_running", running, 0);
        @(posedge clk); #1;
        rst = 0;
        step(0, 1, 0, 0);
        chk("post_reset_running", running, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/speed_scheduler.md
Name: speed_scheduler

Overview:
- Registered difficulty scheduler for the runner game.
- Counts frames while a run is active and steps the speed level 0..MAX_LEVEL every FRAMES_PER_LEVEL frames.
- Drives speed and the physics constants (gravity, duck limit, jump velocity) to the player/obstacle logic.
- Outputs change only at frame boundaries, so physics never sees a mid-frame parameter change.

Parameters:
- FRAMES_PER_LEVEL, 1800, frames spent at each level before stepping up (30 s at 60 Hz).
- MAX_LEVEL, 3, highest level index; the level saturates here. Legal range 0..3.
- FCOUNT_W, 12, width of the frame counter; must satisfy 2^FCOUNT_W > FRAMES_PER_LEVEL.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- frame_in  input  1  single-cycle pulse at the start of each frame.
- start_in  input  1  single-cycle pulse that begins a run.
- pause_in  input  1  level; freezes scheduling while high.
- game_over_in  input  1  single-cycle pulse that ends a run.
- level_out  output  2  current level index.
- speed_out  output  4  1 << level_out.
- gravity_out  output  6  per-frame downward acceleration.
- duck_limit_out  output  8  duck duration in frames.
- vertical_jump_out  output  10  initial jump velocity.
- level_up_out  output  1  one-cycle pulse when the level increments.
- running_out  output  1  high in RUN state.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on rst_in.
- Reset values:
  - State IDLE, level 0, frame counter 0.
  - speed 1, gravity 1, duck_limit 128, vertical_jump 180.
  - level_up_out 0, running_out 0.
- Level table (all outputs registered, driven from the level register):
  - L0: speed 1, gravity 1, duck 128, jump 180.
  - L1: speed 2, gravity 4, duck 64, jump 300.
  - L2: speed 4, gravity 15, duck 32, jump 470.
  - L3: speed 8, gravity 60, duck 16, jump 700.
- States:
  - IDLE:
    - start_in → RUN; clear level and counter.
    - Outputs hold L0 values.
  - RUN:
    - On frame_in: if counter == FRAMES_PER_LEVEL-1, counter ← 0 and level ← min(level+1, MAX_LEVEL). Otherwise counter increments.
    - level_up_out pulses for exactly one cycle, only when the level actually increases. No pulse at saturation.
    - pause_in high → PAUSED.
    - game_over_in → OVER.
  - PAUSED:
    - Counter and level frozen; frame_in ignored.
    - pause_in low → RUN.
    - game_over_in → OVER.
  - OVER:
    - Level and parameters hold their final values; counter frozen.
    - start_in → RUN with level 0 and counter 0.
- Latency: the frame_in that triggers a step is sampled on edge N. New level and parameters plus the level_up_out pulse are visible after edge N, all in the same cycle.
- Simultaneous events:
  - game_over_in has priority over frame_in and pause_in; no level step occurs on that cycle.
  - start_in in RUN or PAUSED is ignored.
  - start_in together with game_over_in in OVER: start wins, and the run restarts.
- MAX_LEVEL = 0: the level never leaves 0 and level_up_out never pulses.
- Reset asserted mid-run: outputs go to reset values immediately (asynchronously) and the state returns to IDLE.
- The counter never wraps past FRAMES_PER_LEVEL-1. At saturation it keeps cycling 0..FRAMES_PER_LEVEL-1 with no effect.

Optional Feature:
- Macro: SPEED_BOOST_EN.
- When defined:
  - Adds port boost_in (input, 1): a power-up request.
  - In RUN, a boost_in pulse arms a boost of FRAMES_PER_LEVEL/4 frames, starting at the next frame_in.
  - While boost is active, every output uses the table row for min(level+1, 3). level_out still reports the base level.
  - Boost ends at a frame boundary.
  - A re-pulse during an active boost reloads the remaining-frame counter.
  - Boost frame counting freezes in PAUSED and clears on OVER and on reset.
- When undefined: no boost_in port, no boost logic; behaviour is exactly as above.

Test Plan:
- FRAMES_PER_LEVEL=4. Reset, start_in, 4 frame_in pulses → after the 4th frame: level_out 1, speed 2, gravity 4, duck 64, jump 300, and one level_up_out pulse.
- 16 frames in RUN → level saturates at 3 (speed 8, gravity 60, duck 16, jump 700); exactly 3 level_up_out pulses; no pulse on frames 13–16.
- 2 frames in RUN, pause_in high for 10 frames, then low, then 2 more frames → level steps to 1 only on the 4th unpaused frame.
- game_over_in and frame_in in the same cycle at counter 3 → OVER, level unchanged, no level_up_out. Then start_in → level 0, speed 1.
- Reset asserted mid-cycle while at level 2 → outputs read L0 values before the next clk_in edge; running_out 0.
- With SPEED_BOOST_EN, at level 1: boost_in → after the next frame, gravity 15 and jump 470 for 1 frame, then back to gravity 4; level_out stays 1 throughout.
